cfg_mem_model: RTL and testbench

Parametrised behavioural/synthesisable configuration memory for block-level benches and FPGA bring-up images. It generalises the fixed single-cycle address-echo model with the following:
- configurable address/data width and depth
- programmable read latency with full pipelining
- byte-enabled write port
- out-of-range detection
- access counters

It sits behind any config-register reader (mem_rd_* master) in the logic tree.

---
 rtl/cfg_mem_model.sv | 150 +++++++++++++++
 tb/tb_cfg_mem_model.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_mem_model.sv
// Parametrised config memory: address-pattern default data, byte-enabled writes,
// pipelined reads, range errors and saturating counters. Option: CFG_MEM_ERR_INJ_EN.
module cfg_mem_model #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int U_DLY  = 1
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic                mem_rd_en,
  input  logic [ADDR_W-1:0]   mem_rd_addr,
  output logic [DATA_W-1:0]   mem_rd_data,
  output logic                mem_rd_data_valid,
  output logic                mem_rd_err,
  input  logic                mem_wr_en,
  input  logic [ADDR_W-1:0]   mem_wr_addr,
  input  logic [DATA_W-1:0]   mem_wr_data,
  input  logic [DATA_W/8-1:0] mem_wr_be,
  output logic                mem_wr_err,
  output logic [31:0]         mem_rd_cnt,
  output logic [31:0]         mem_wr_cnt
`ifdef CFG_MEM_ERR_INJ_EN
  ,
  input  logic                err_inj_en,
  input  logic [ADDR_W-1:0]   err_inj_addr
`endif
);

  localparam int NBYTE = DATA_W / 8;
  localparam int NREP  = DATA_W / ADDR_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
    $error("cfg_mem_model: RD_LAT must be within 1..8");
  end
  if ((DATA_W % 8) != 0 || DATA_W < ADDR_W) begin : g_bad_data_w
    $error("cfg_mem_model: DATA_W must be a multiple of 8 and >= ADDR_W");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << ADDR_W) || U_DLY < 0) begin : g_bad_depth
    $error("cfg_mem_model: DEPTH must be 1..2**ADDR_W and U_DLY non-negative");
  end

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < NREP; i++) p[i*ADDR_W +: ADDR_W] = a;
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] dead_fill();
    logic [15:0]       w;
    logic [DATA_W-1:0] d;
    w = 16'hDEAD;
    for (int unsigned i = 0; i < DATA_W; i++) d[i] = w[i % 16];
    return d;
  endfunction

  localparam logic [DATA_W-1:0] DEAD_WORD = dead_fill();

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  written;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              rd_in_rng, wr_in_rng, wr_take;
  logic [DATA_W-1:0] wr_base, wr_word, rd_word;
  beat_t             req, tap;

  assign rd_idx = mem_rd_addr[IDX_W-1:0];
  assign wr_idx = mem_wr_addr[IDX_W-1:0];

  always_comb begin
    rd_in_rng = {1'b0, mem_rd_addr} < DEPTH_A;
    wr_in_rng = {1'b0, mem_wr_addr} < DEPTH_A;
    wr_take   = mem_wr_en && wr_in_rng;
    wr_base   = written[wr_idx] ? mem[wr_idx] : pat(mem_wr_addr);
    wr_word   = wr_base;
    for (int unsigned b = 0; b < NBYTE; b++)
      if (mem_wr_be[b]) wr_word[b*8 +: 8] = mem_wr_data[b*8 +: 8];
    // Same-cycle write to the read address bypasses the array (write-first)
    if (!rd_in_rng)
      rd_word = DEAD_WORD;
    else if (wr_take && mem_wr_addr == mem_rd_addr)
      rd_word = wr_word;
    else if (written[rd_idx])
      rd_word = mem[rd_idx];
    else
      rd_word = pat(mem_rd_addr);
`ifdef CFG_MEM_ERR_INJ_EN
    if (err_inj_en && mem_rd_addr == err_inj_addr) rd_word[0] = ~rd_word[0];
`endif
    req.vld  = mem_rd_en;
    req.err  = mem_rd_en && !rd_in_rng;
    req.data = rd_word;
  end

  always_ff @(posedge clk_sys) begin
    if (!rst && wr_take) mem[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      written    <= '0;
      mem_wr_err <= 1'b0;
      mem_rd_cnt <= '0;
      mem_wr_cnt <= '0;
    end else begin
      if (wr_take) written[wr_idx] <= 1'b1;
      mem_wr_err <= mem_wr_en && !wr_in_rng;
      if (mem_rd_en && mem_rd_cnt != '1) mem_rd_cnt <= mem_rd_cnt + 32'd1;
      if (wr_take && mem_wr_cnt != '1) mem_wr_cnt <= mem_wr_cnt + 32'd1;
    end
  end

  // The output register is the last latency stage, so only RD_LAT-1 stages precede it
  if (RD_LAT == 1) begin : g_lat1
    assign tap = req;
  end else begin : g_pipe
    beat_t stage [RD_LAT-1];
    always_ff @(posedge clk_sys) begin
      if (rst) begin
        for (int unsigned i = 0; i < RD_LAT-1; i++) stage[i] <= '0;
      end else begin
        stage[0] <= req;
        for (int unsigned i = 1; i < RD_LAT-1; i++) stage[i] <= stage[i-1];
      end
    end
    assign tap = stage[RD_LAT-2];
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      mem_rd_data       <= '0;
      mem_rd_data_valid <= 1'b0;
      mem_rd_err        <= 1'b0;
    end else begin
      mem_rd_data_valid <= tap.vld;
      mem_rd_err        <= tap.vld && tap.err;
      if (tap.vld) mem_rd_data <= tap.data;
    end
  end

endmodule

// File: tb/tb_cfg_mem_model.sv
// Bench for cfg_mem_model (RD_LAT=3, DEPTH=256): cycle-by-cycle reference model
// plus directed vectors with literal expectations.
module tb_cfg_mem_model;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd_en = 1'b0;
  logic [AW-1:0] mem_rd_addr = '0;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rd_data_valid;
  logic          mem_rd_err;
  logic          mem_wr_en = 1'b0;
  logic [AW-1:0] mem_wr_addr = '0;
  logic [DW-1:0] mem_wr_data = '0;
  logic [3:0]    mem_wr_be = '0;
  logic          mem_wr_err;
  logic [31:0]   mem_rd_cnt;
  logic [31:0]   mem_wr_cnt;

  cfg_mem_model #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(LAT), .U_DLY(1)
  ) dut (
    .clk_sys(clk_sys), .rst(rst),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_err(mem_rd_err),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_err(mem_wr_err),
    .mem_rd_cnt(mem_rd_cnt), .mem_wr_cnt(mem_wr_cnt)
`ifdef CFG_MEM_ERR_INJ_EN
    , .err_inj_en(1'b0), .err_inj_addr('0)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int failures = 0;
  int unsigned edges = 0;
  always @(posedge clk_sys) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: read data is decided at request time, delivered LAT edges later
  typedef struct {
    int unsigned due;
    logic [31:0] d;
    logic        e;
  } beat_t;

  beat_t       q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];
  logic [31:0] m_rd_cnt = '0;
  logic [31:0] m_wr_cnt = '0;
  logic [31:0] last_d = '0;
  logic        m_werr = 1'b0;
  bit          chk_on = 1'b0;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a, a};
  endfunction

  initial begin : model
    beat_t       b;
    logic [31:0] w;
    int          a;
    forever begin
      @(negedge clk_sys);
      if (chk_on) begin
        if (q.size() > 0 && q[0].due == edges) begin
          b = q.pop_front();
          last_d = b.d;
          chk1("m_rd_valid", mem_rd_data_valid, 1'b1);
          chk1("m_rd_err", mem_rd_err, b.e);
        end else begin
          chk1("m_rd_valid_idle", mem_rd_data_valid, 1'b0);
          chk1("m_rd_err_idle", mem_rd_err, 1'b0);
        end
        chk("m_rd_data", mem_rd_data, last_d);
        chk("m_rd_cnt", mem_rd_cnt, m_rd_cnt);
        chk("m_wr_cnt", mem_wr_cnt, m_wr_cnt);
        chk1("m_wr_err", mem_wr_err, m_werr);
      end
      if (rst) begin
        q.delete();
        m_rd_cnt = '0;
        m_wr_cnt = '0;
        m_werr   = 1'b0;
        last_d   = '0;
        foreach (m_written[i]) m_written[i] = 1'b0;
        chk_on   = 1'b1;
      end else begin
        m_werr = 1'b0;
        if (mem_wr_en) begin
          a = int'(mem_wr_addr);
          if (a < DEPTH) begin
            w = m_written[a] ? m_mem[a] : pat(mem_wr_addr);
            for (int k = 0; k < 4; k++)
              if (mem_wr_be[k]) w[k*8 +: 8] = mem_wr_data[k*8 +: 8];
            m_mem[a] = w;
            m_written[a] = 1'b1;
            if (m_wr_cnt != 32'hFFFF_FFFF) m_wr_cnt++;
          end else begin
            m_werr = 1'b1;
          end
        end
        if (mem_rd_en) begin
          a = int'(mem_rd_addr);
          b.due = edges + int'(LAT);
          if (a < DEPTH) begin
            b.d = m_written[a] ? m_mem[a] : pat(mem_rd_addr);
            b.e = 1'b0;
          end else begin
            b.d = 32'hDEAD_DEAD;
            b.e = 1'b1;
          end
          q.push_back(b);
          if (m_rd_cnt != 32'hFFFF_FFFF) m_rd_cnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d; mem_wr_be = be;
    step();
    mem_wr_en = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [15:0] a, input logic [31:0] d, input logic e);
    mem_rd_en = 1'b1; mem_rd_addr = a;
    step();
    mem_rd_en = 1'b0;
    repeat (LAT-1) step();
    chk1({name, "_vld"}, mem_rd_data_valid, 1'b1);
    chk(name, mem_rd_data, d);
    chk1({name, "_err"}, mem_rd_err, e);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_rd_cnt", mem_rd_cnt, 32'd0);
    chk("rst_wr_cnt", mem_wr_cnt, 32'd0);
    chk1("rst_valid", mem_rd_data_valid, 1'b0);
    chk("rst_data", mem_rd_data, 32'd0);

    rd_lit("rd_0012", 16'h0012, 32'h0012_0012, 1'b0);
    rd_lit("rd_oor_1234", 16'h1234, 32'hDEAD_DEAD, 1'b1);
    chk("rd_cnt_2", mem_rd_cnt, 32'd2);

    for (int i = 1; i <= 5; i++) begin
      mem_rd_en = 1'b1; mem_rd_addr = 16'(i);
      step();
    end
    mem_rd_en = 1'b0;
    chk("b2b_3", mem_rd_data, 32'h0003_0003);
    step();
    chk("b2b_4", mem_rd_data, 32'h0004_0004);
    chk1("b2b_4_vld", mem_rd_data_valid, 1'b1);
    step();
    chk("b2b_5", mem_rd_data, 32'h0005_0005);
    step();
    chk1("b2b_end_vld", mem_rd_data_valid, 1'b0);
    chk("b2b_hold", mem_rd_data, 32'h0005_0005);

    wr(16'h0010, 32'hAABB_CCDD, 4'b0011);
    rd_lit("rd_be_lo", 16'h0010, 32'h0010_CCDD, 1'b0);
    wr(16'h0010, 32'h1122_0000, 4'b1100);
    rd_lit("rd_be_hi", 16'h0010, 32'h1122_CCDD, 1'b0);
    chk("wr_cnt_2", mem_wr_cnt, 32'd2);

    mem_wr_en = 1'b1; mem_wr_addr = 16'h0020; mem_wr_data = 32'hCAFE_F00D; mem_wr_be = 4'hF;
    mem_rd_en = 1'b1; mem_rd_addr = 16'h0020;
    step();
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    repeat (LAT-1) step();
    chk("rd_wr_first", mem_rd_data, 32'hCAFE_F00D);

    wr(16'h0100, 32'h1234_5678, 4'hF);
    chk1("wr_err_pulse", mem_wr_err, 1'b1);
    step();
    chk1("wr_err_clear", mem_wr_err, 1'b0);
    chk("wr_cnt_oor", mem_wr_cnt, 32'd3);
    rd_lit("rd_0000", 16'h0000, 32'h0000_0000, 1'b0);
    rd_lit("rd_00ff", 16'h00FF, 32'h00FF_00FF, 1'b0);
    rd_lit("rd_oor_0100", 16'h0100, 32'hDEAD_DEAD, 1'b1);

    wr(16'h0030, 32'hFFFF_FFFF, 4'b0000);
    rd_lit("rd_be0", 16'h0030, 32'h0030_0030, 1'b0);
    chk("wr_cnt_be0", mem_wr_cnt, 32'd4);
    wr(16'h0030, 32'h0000_00AB, 4'b0001);
    rd_lit("rd_be0_then_b0", 16'h0030, 32'h0030_00AB, 1'b0);

    mem_rd_en = 1'b1; mem_rd_addr = 16'h0040;
    step();
    rst = 1'b1;
    mem_wr_en = 1'b1; mem_wr_addr = 16'h0050; mem_wr_data = 32'h1234_5678; mem_wr_be = 4'hF;
    mem_rd_addr = 16'h0050;
    step();
    rst = 1'b0; mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    repeat (6) begin
      chk1("no_vld_after_rst", mem_rd_data_valid, 1'b0);
      step();
    end
    chk("rst_mid_rd_cnt", mem_rd_cnt, 32'd0);
    chk("rst_mid_wr_cnt", mem_wr_cnt, 32'd0);
    rd_lit("rd_0050_after_rst", 16'h0050, 32'h0050_0050, 1'b0);
    rd_lit("rd_0010_after_rst", 16'h0010, 32'h0010_0010, 1'b0);

    for (int i = 0; i < 24; i++) begin
      mem_wr_en   = (i % 3) != 2;
      mem_wr_addr = 16'((i * 37) % 300);
      mem_wr_data = 32'((i + 1) * 32'h9E37_79B9);
      mem_wr_be   = 4'(i);
      mem_rd_en   = (i % 4) != 3;
      mem_rd_addr = (i % 2 == 1) ? 16'(((i - 1) * 37) % 300) : 16'((i * 53) % 290);
      step();
    end
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
    repeat (LAT + 2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
